sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Shares one `sdram` controller channel among `NUM_CLIENTS` requesters using the same toggle req/ack handshake on both sides. Sits between the cartridge/mapper/loader clients and a single `sdram` channel, so more than three agents can reach SDRAM. Round-robin grant, one transaction in flight at a time, read data returned per client.

## Interface
Parameters:
- `NUM_CLIENTS`, 4: number of requesters (≥2); index width `$clog2(NUM_CLIENTS)`
- `ADDR_BITS`, 24: word address width, same as the downstream channel
- `DATA_BITS`, 16: data width

Ports:
- `clk`  in  1  controller clock, same domain as `sdram_clk`
- `reset`  in  1  asynchronous, active-high
- `cl_req`  in  NUM_CLIENTS  per-client request toggle
- `cl_ack`  out  NUM_CLIENTS  per-client acknowledge toggle
- `cl_we`  in  NUM_CLIENTS  1 = write, 0 = read
- `cl_address`  in  NUM_CLIENTS×ADDR_BITS  word address
- `cl_data_write`  in  NUM_CLIENTS×DATA_BITS  write data
- `cl_data_read`  out  NUM_CLIENTS×DATA_BITS  read data, valid when `cl_req[i]==cl_ack[i]`
- `mem_req`  out  1  downstream request toggle
- `mem_ack`  in  1  downstream acknowledge toggle
- `mem_we`  out  1  downstream write enable
- `mem_address`  out  ADDR_BITS  downstream address
- `mem_data_write`  out  DATA_BITS  downstream write data
- `mem_data_read`  in  DATA_BITS  downstream read data

## Operation
- Client i pending when `cl_req[i] != cl_ack[i]`. Client holds `cl_we/cl_address/cl_data_write` stable from toggle until ack matches.
- States: `RESYNC`, `IDLE`, `BUSY`.
- `RESYNC`: entered on reset; `mem_req <= mem_ack`; → `IDLE` next edge. Tolerates a downstream ack left mismatched by reset.
- `IDLE`: if any pending, pick winner, latch its fields into `mem_we/mem_address/mem_data_write`, toggle `mem_req`, store `grant`, → `BUSY`. No pending: stay.
- `BUSY`: when sampled `mem_ack == mem_req`: if `mem_we==0` load `cl_data_read[grant] <= mem_data_read`; toggle `cl_ack[grant]`; `last <= grant`; → `IDLE`. Writes leave `cl_data_read[grant]` unchanged.
- Round-robin: search order `last+1, last+2, …` modulo `NUM_CLIENTS`; first pending wins. `last` resets to `NUM_CLIENTS-1` → client 0 first after reset.
- Requests arriving during `BUSY` wait; never dropped. Double toggle before ack is a protocol violation; behaviour unspecified.
- Only granted client's `cl_ack`/`cl_data_read` change; others held.

## Timing
- Reset values: `cl_ack` = 0, `cl_data_read` = 0, `mem_req` = 0, `mem_we` = 0, `mem_address` = 0, `mem_data_write` = 0, state `RESYNC`, `last` = `NUM_CLIENTS-1`.
- Client toggle at edge T → `mem_req` toggles at edge T+1 (state `IDLE`).
- Downstream match sampled at edge C → `cl_ack` toggle and data at edge C (registered, visible after C).
- Back-to-back: next grant at edge C+1; one `IDLE` cycle between transactions, two cycles added latency per transaction.
- Reset mid-`BUSY`: transaction abandoned, no client ack; `RESYNC` realigns `mem_req`. Clients reset with the arbiter.

## Configuration
- `SDRAM_ARBITER_PRIORITY_EN` defined: client 0 has fixed top priority; if pending in `IDLE` it wins regardless of `last`; granting client 0 does not update `last`; clients 1..N-1 round-robin among themselves.
- Not defined: pure round-robin over all clients as above.

## Structure
- Package `sdram_arb_pkg`: state enum `arb_state_t` (`RESYNC`, `IDLE`, `BUSY`).
- Sub-module `sdram_arb_rr`: combinational round-robin picker (inputs pending vector, `last`; outputs `valid`, `winner`), holds the priority-override logic under the macro.

## Test plan
- Reset, client 1 writes `'h000010`=`'hBEEF`, then reads it → `cl_data_read[1]=='hBEEF`, `cl_ack[1]` toggles once per op, others unchanged.
- Clients 0–3 toggle same edge, all read, each client wrote a distinct value beforehand (`'h1111`…`'h4444`) → grant order 0,1,2,3; each gets own data.
- After grant to 2, clients 0 and 3 pending → 3 granted before 0 (wrap-around).
- Client 1 continuously re-requests while client 2 pending → grants alternate 1,2,1,2; no starvation.
- Assert `reset` while `BUSY` with downstream ack pending → after release, `cl_ack`=0, `mem_req==mem_ack` after `RESYNC`, next request completes correctly.
- With `SDRAM_ARBITER_PRIORITY_EN`: clients 0,1,2 pending, `last`=0 → order 0,1,2; client 0 re-toggles during 1's access → order 0,1,0,2.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and helpers for the SDRAM channel arbiter
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        BUSY   = 2'd2
    } arb_state_t;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// rtl/sdram_arbiter_if.sv - client-side and memory-side toggle req/ack bundle of the arbiter
interface sdram_arbiter_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_BITS   = 24,
    parameter int DATA_BITS   = 16
);
    logic [NUM_CLIENTS-1:0]                cl_req;
    logic [NUM_CLIENTS-1:0]                cl_ack;
    logic [NUM_CLIENTS-1:0]                cl_we;
    logic [NUM_CLIENTS-1:0][ADDR_BITS-1:0] cl_address;
    logic [NUM_CLIENTS-1:0][DATA_BITS-1:0] cl_data_write;
    logic [NUM_CLIENTS-1:0][DATA_BITS-1:0] cl_data_read;
    logic                                  mem_req;
    logic                                  mem_ack;
    logic                                  mem_we;
    logic [ADDR_BITS-1:0]                  mem_address;
    logic [DATA_BITS-1:0]                  mem_data_write;
    logic [DATA_BITS-1:0]                  mem_data_read;

    // master: the clients plus the downstream controller; slave: the arbiter
    modport master (
        output cl_req, cl_we, cl_address, cl_data_write, mem_ack, mem_data_read,
        input  cl_ack, cl_data_read, mem_req, mem_we, mem_address, mem_data_write
    );

    modport slave (
        input  cl_req, cl_we, cl_address, cl_data_write, mem_ack, mem_data_read,
        output cl_ack, cl_data_read, mem_req, mem_we, mem_address, mem_data_write
    );
endinterface

// File: rtl/sdram_arb_rr.sv
// rtl/sdram_arb_rr.sv - round-robin picker; SDRAM_ARBITER_PRIORITY_EN gives client 0 fixed top priority
module sdram_arb_rr
    import sdram_arb_pkg::*;
#(
    parameter  int NUM_CLIENTS = 4,
    localparam int IW          = idx_bits(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] pending,
    input  logic [IW-1:0]          last,
    output logic                   valid,
    output logic [IW-1:0]          winner
);

    logic [NUM_CLIENTS-1:0] cand;
    logic [IW-1:0]          idx;

    always_comb begin
        cand   = pending;
`ifdef SDRAM_ARBITER_PRIORITY_EN
        cand[0] = 1'b0;
`endif
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        // Scan last+1 .. last+N so the most recently served client is checked last
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            idx = IW'((int'(last) + k) % NUM_CLIENTS);
            if (!valid && cand[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
`ifdef SDRAM_ARBITER_PRIORITY_EN
        if (pending[0]) begin
            valid  = 1'b1;
            winner = '0;
        end
`endif
    end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - shares one sdram toggle req/ack channel among NUM_CLIENTS; option SDRAM_ARBITER_PRIORITY_EN
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter  int NUM_CLIENTS = 4,
    parameter  int ADDR_BITS   = 24,
    parameter  int DATA_BITS   = 16,
    localparam int IW          = idx_bits(NUM_CLIENTS)
) (
    input  logic            clk,
    input  logic            reset,
    sdram_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_RESYNC = RESYNC;
    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_BUSY   = BUSY;

    logic [1:0]                            state;
    logic [IW-1:0]                         last;
    logic [IW-1:0]                         grant;
    logic [NUM_CLIENTS-1:0]                cl_ack_q;
    logic [NUM_CLIENTS-1:0][DATA_BITS-1:0] cl_data_read_q;
    logic                                  mem_req_q;
    logic                                  mem_we_q;
    logic [ADDR_BITS-1:0]                  mem_address_q;
    logic [DATA_BITS-1:0]                  mem_data_write_q;

    logic [NUM_CLIENTS-1:0] pending;
    logic                   pick_valid;
    logic [IW-1:0]          pick_winner;

    assign pending = bus.cl_req ^ cl_ack_q;

    sdram_arb_rr #(
        .NUM_CLIENTS (NUM_CLIENTS)
    ) u_rr (
        .pending (pending),
        .last    (last),
        .valid   (pick_valid),
        .winner  (pick_winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_RESYNC;
            last             <= IW'(NUM_CLIENTS - 1);
            grant            <= '0;
            cl_ack_q         <= '0;
            cl_data_read_q   <= '0;
            mem_req_q        <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_address_q    <= '0;
            mem_data_write_q <= '0;
        end else begin
            case (state)
                // Downstream may still hold an ack from before reset; adopt it as the idle level
                ST_RESYNC: begin
                    mem_req_q <= bus.mem_ack;
                    state     <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant            <= pick_winner;
                        mem_we_q         <= bus.cl_we[pick_winner];
                        mem_address_q    <= bus.cl_address[pick_winner];
                        mem_data_write_q <= bus.cl_data_write[pick_winner];
                        mem_req_q        <= ~mem_req_q;
                        state            <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.mem_ack == mem_req_q) begin
                        if (!mem_we_q) begin
                            cl_data_read_q[grant] <= bus.mem_data_read;
                        end
                        cl_ack_q[grant] <= ~cl_ack_q[grant];
`ifdef SDRAM_ARBITER_PRIORITY_EN
                        if (grant != '0) begin
                            last <= grant;
                        end
`else
                        last <= grant;
`endif
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_RESYNC;
            endcase
        end
    end

    assign bus.cl_ack         = cl_ack_q;
    assign bus.cl_data_read   = cl_data_read_q;
    assign bus.mem_req        = mem_req_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_data_write = mem_data_write_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - directed self-checking bench for sdram_arbiter with a toggle-handshake memory model
module tb_sdram_arbiter;

    localparam int RESP_LAT = 2;

    logic clk;
    logic reset;

    sdram_arbiter_if #(.NUM_CLIENTS(4), .ADDR_BITS(24), .DATA_BITS(16)) bus ();

    sdram_arbiter #(
        .NUM_CLIENTS (4),
        .ADDR_BITS   (24),
        .DATA_BITS   (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [logic [23:0]];
    int          wait_cnt = 0;
    bit          resp_en  = 1'b1;
    logic [3:0]  prev_ack = 4'b0000;
    int          ack_log[$];
    int          n0, n1, n2;
    bit          done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mem_step();
        if (!resp_en) begin
            wait_cnt = 0;
            return;
        end
        if (bus.mem_req !== bus.mem_ack) begin
            if (wait_cnt < RESP_LAT) begin
                wait_cnt++;
            end else begin
                wait_cnt = 0;
                if (bus.mem_we) mem[bus.mem_address] = bus.mem_data_write;
                else bus.mem_data_read = mem.exists(bus.mem_address) ? mem[bus.mem_address] : 16'h0000;
                bus.mem_ack = bus.mem_req;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        mem_step();
        for (int i = 0; i < 4; i++) begin
            if (bus.cl_ack[i] !== prev_ack[i]) ack_log.push_back(i);
        end
        prev_ack = bus.cl_ack;
    endtask

    task automatic client_req(input int i, input logic we, input logic [23:0] a, input logic [15:0] d);
        bus.cl_we[i]         = we;
        bus.cl_address[i]    = a;
        bus.cl_data_write[i] = d;
        bus.cl_req[i]        = ~bus.cl_req[i];
    endtask

    task automatic wait_all(input string tag, input int budget);
        done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (bus.cl_req === bus.cl_ack) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    function automatic int log_at(input int k);
        return (k < ack_log.size()) ? ack_log[k] : -1;
    endfunction

    initial begin
        reset              = 1'b1;
        bus.cl_req         = '0;
        bus.cl_we          = '0;
        bus.cl_address     = '0;
        bus.cl_data_write  = '0;
        bus.mem_ack        = 1'b0;
        bus.mem_data_read  = '0;
        repeat (3) tick();

        chk("rst_cl_ack", 64'(bus.cl_ack), 64'h0);
        chk("rst_cl_data_read", bus.cl_data_read, 64'h0);
        chk("rst_mem_req", 64'(bus.mem_req), 64'h0);
        chk("rst_mem_we", 64'(bus.mem_we), 64'h0);
        chk("rst_mem_address", 64'(bus.mem_address), 64'h0);
        chk("rst_mem_data_write", 64'(bus.mem_data_write), 64'h0);

        reset = 1'b0;
        repeat (2) tick();

        // Client 1 write then read of 0x000010
        client_req(1, 1'b1, 24'h000010, 16'hBEEF);
        tick();
        chk("wr_mem_req_latency", 64'(bus.mem_req), 64'h1);
        chk("wr_mem_we", 64'(bus.mem_we), 64'h1);
        chk("wr_mem_address", 64'(bus.mem_address), 64'h10);
        chk("wr_mem_data_write", 64'(bus.mem_data_write), 64'hBEEF);
        wait_all("wr_done", 40);
        chk("wr_cl_ack", 64'(bus.cl_ack), 64'b0010);
        chk("wr_data_read_unchanged", 64'(bus.cl_data_read[1]), 64'h0);
        client_req(1, 1'b0, 24'h000010, 16'h0000);
        wait_all("rd_done", 40);
        chk("rd_cl_ack", 64'(bus.cl_ack), 64'b0000);
        chk("rd_data1", 64'(bus.cl_data_read[1]), 64'hBEEF);
        chk("rd_others_held", 64'({bus.cl_data_read[3], bus.cl_data_read[2], bus.cl_data_read[0]}), 64'h0);

        // Each client writes its own value, then all four read on the same edge
        for (int i = 0; i < 4; i++) begin
            client_req(i, 1'b1, 24'(24'h100 + i), 16'(16'h1111 * (i + 1)));
            wait_all("prewrite_done", 40);
        end
        ack_log.delete();
        for (int i = 0; i < 4; i++) client_req(i, 1'b0, 24'(24'h100 + i), 16'h0000);
        wait_all("rd4_done", 200);
        chk("rd4_count", 64'(ack_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("rd4_order", 64'(log_at(i)), 64'(i));
            chk("rd4_data", 64'(bus.cl_data_read[i]), 64'(16'(16'h1111 * (i + 1))));
        end

`ifndef SDRAM_ARBITER_PRIORITY_EN
        // Wrap-around: after client 2 is granted, 3 must beat 0
        ack_log.delete();
        client_req(2, 1'b0, 24'h000102, 16'h0000);
        tick();
        client_req(0, 1'b0, 24'h000100, 16'h0000);
        client_req(3, 1'b0, 24'h000103, 16'h0000);
        wait_all("wrap_done", 200);
        chk("wrap_count", 64'(ack_log.size()), 64'd3);
        chk("wrap_first", 64'(log_at(0)), 64'd2);
        chk("wrap_second", 64'(log_at(1)), 64'd3);
        chk("wrap_third", 64'(log_at(2)), 64'd0);
`endif

        // Client 1 keeps re-requesting while client 2 waits
        ack_log.delete();
        n1 = 0;
        n2 = 0;
        done = 1'b0;
        client_req(1, 1'b0, 24'h000010, 16'h0000);
        client_req(2, 1'b0, 24'h000102, 16'h0000);
        for (int c = 0; c < 400; c++) begin
            tick();
            if (bus.cl_ack[1] === bus.cl_req[1] && n1 < 2) begin
                client_req(1, 1'b0, 24'h000010, 16'h0000);
                n1++;
            end
            if (bus.cl_ack[2] === bus.cl_req[2] && n2 < 1) begin
                client_req(2, 1'b0, 24'h000102, 16'h0000);
                n2++;
            end
            if (n1 == 2 && n2 == 1 && bus.cl_ack === bus.cl_req) begin
                done = 1'b1;
                break;
            end
        end
        chk("fair_done", 64'(done), 64'd1);
        chk("fair_count", 64'(ack_log.size()), 64'd5);
        chk("fair_g0", 64'(log_at(0)), 64'd1);
        chk("fair_g1", 64'(log_at(1)), 64'd2);
        chk("fair_g2", 64'(log_at(2)), 64'd1);
        chk("fair_g3", 64'(log_at(3)), 64'd2);
        chk("fair_g4", 64'(log_at(4)), 64'd1);
        chk("fair_data1", 64'(bus.cl_data_read[1]), 64'hBEEF);
        chk("fair_data2", 64'(bus.cl_data_read[2]), 64'h3333);

        // Reset while BUSY; the downstream completes during reset
        resp_en = 1'b0;
        client_req(0, 1'b0, 24'h000010, 16'h0000);
        tick();
        tick();
        chk("midbusy_outstanding", 64'(bus.mem_req !== bus.mem_ack), 64'd1);
        bus.mem_ack = bus.mem_req;
        reset       = 1'b1;
        bus.cl_req  = '0;
        tick();
        chk("midrst_cl_ack", 64'(bus.cl_ack), 64'h0);
        chk("midrst_mem_req", 64'(bus.mem_req), 64'h0);
        chk("midrst_data_read", bus.cl_data_read, 64'h0);
        reset = 1'b0;
        tick();
        chk("resync_align", 64'(bus.mem_req === bus.mem_ack), 64'd1);
        chk("resync_cl_ack", 64'(bus.cl_ack), 64'h0);
        resp_en = 1'b1;
        tick();
        client_req(3, 1'b0, 24'h000103, 16'h0000);
        wait_all("post_rst_done", 40);
        chk("post_rst_ack", 64'(bus.cl_ack), 64'b1000);
        chk("post_rst_data3", 64'(bus.cl_data_read[3]), 64'h4444);
        chk("post_rst_data0", 64'(bus.cl_data_read[0]), 64'h0);

`ifdef SDRAM_ARBITER_PRIORITY_EN
        // Client 0 re-requests during client 1's access and jumps ahead of 2
        ack_log.delete();
        n0 = 0;
        done = 1'b0;
        client_req(0, 1'b0, 24'h000100, 16'h0000);
        client_req(1, 1'b0, 24'h000101, 16'h0000);
        client_req(2, 1'b0, 24'h000102, 16'h0000);
        for (int c = 0; c < 400; c++) begin
            tick();
            if (n0 == 0 && ack_log.size() >= 1) begin
                tick();
                client_req(0, 1'b0, 24'h000100, 16'h0000);
                n0 = 1;
            end
            if (n0 == 1 && bus.cl_ack === bus.cl_req) begin
                done = 1'b1;
                break;
            end
        end
        chk("prio_done", 64'(done), 64'd1);
        chk("prio_count", 64'(ack_log.size()), 64'd4);
        chk("prio_g0", 64'(log_at(0)), 64'd0);
        chk("prio_g1", 64'(log_at(1)), 64'd1);
        chk("prio_g2", 64'(log_at(2)), 64'd0);
        chk("prio_g3", 64'(log_at(3)), 64'd2);
        chk("prio_data0", 64'(bus.cl_data_read[0]), 64'h1111);
        chk("prio_data2", 64'(bus.cl_data_read[2]), 64'h3333);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
